// File: rtl/wb_regfile.sv
// MEM/WB pipeline latch with stall/flush feeding a 2**AW x DW register file.
// Two combinational read ports bypass the latch so ID never sees stale data.
module wb_regfile #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic [DW-1:0] i_w_reg_data,
    input  logic [AW-1:0] i_w_reg_addr,
    input  logic          i_wd,
    input  logic          re1,
    input  logic [AW-1:0] raddr1,
    output logic [DW-1:0] rdata1,
    input  logic          re2,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata2,
    output logic [DW-1:0] wb_w_reg_data,
    output logic [AW-1:0] wb_w_reg_addr,
    output logic          wb_wd
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] wb_data_q, wb_data_d;
    logic [AW-1:0] wb_addr_q, wb_addr_d;
    logic          wb_wd_q, wb_wd_d;
    logic [DW-1:0] regs_q [DEPTH];
    logic [DW-1:0] regs_d [DEPTH];
    logic          commit;

    // Register 0 is hard-wired to zero, so a commit to it is simply dropped.
    assign commit = wb_wd_q && (wb_addr_q != '0);

    always_comb begin
        wb_data_d = wb_data_q;
        wb_addr_d = wb_addr_q;
        wb_wd_d   = wb_wd_q;
        if (flush) begin
            wb_data_d = '0;
            wb_addr_d = '0;
            wb_wd_d   = 1'b0;
        end else if (!stall) begin
            wb_data_d = i_w_reg_data;
            wb_addr_d = i_w_reg_addr;
            wb_wd_d   = i_wd;
        end
    end

    // Commit always uses the pre-edge latch, even when flushing or stalling.
    always_comb begin
        regs_d = regs_q;
        if (commit) begin
            regs_d[wb_addr_q] = wb_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_data_q <= '0;
            wb_addr_q <= '0;
            wb_wd_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            wb_data_q <= wb_data_d;
            wb_addr_q <= wb_addr_d;
            wb_wd_q   <= wb_wd_d;
            regs_q    <= regs_d;
        end
    end

    function automatic logic [DW-1:0] read_mux(
        input logic          re,
        input logic [AW-1:0] addr,
        input logic          byp_wd,
        input logic [AW-1:0] byp_addr,
        input logic [DW-1:0] byp_data,
        input logic [DW-1:0] arr_data
    );
        if (!re || addr == '0) begin
            return '0;
        end
        if (byp_wd && byp_addr == addr) begin
            return byp_data;
        end
        return arr_data;
    endfunction

    always_comb begin
        rdata1 = read_mux(re1, raddr1, wb_wd_q, wb_addr_q, wb_data_q, regs_q[raddr1]);
        rdata2 = read_mux(re2, raddr2, wb_wd_q, wb_addr_q, wb_data_q, regs_q[raddr2]);
    end

    assign wb_w_reg_data = wb_data_q;
    assign wb_w_reg_addr = wb_addr_q;
    assign wb_wd         = wb_wd_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed and randomized bench for wb_regfile against a behavioural register-file model.
module tb_wb_regfile;
    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] i_w_reg_data;
    logic [4:0]  i_w_reg_addr;
    logic        i_wd;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] wb_w_reg_data;
    logic [4:0]  wb_w_reg_addr;
    logic        wb_wd;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: architectural registers plus the pending MEM/WB entry.
    logic [31:0] mregs [32];
    logic [31:0] m_data;
    logic [4:0]  m_addr;
    logic        m_wd;

    wb_regfile #(.DW(32), .AW(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .i_w_reg_data (i_w_reg_data),
        .i_w_reg_addr (i_w_reg_addr),
        .i_wd         (i_wd),
        .re1          (re1),
        .raddr1       (raddr1),
        .rdata1       (rdata1),
        .re2          (re2),
        .raddr2       (raddr2),
        .rdata2       (rdata2),
        .wb_w_reg_data(wb_w_reg_data),
        .wb_w_reg_addr(wb_w_reg_addr),
        .wb_wd        (wb_wd)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        m_data = 32'd0;
        m_addr = 5'd0;
        m_wd   = 1'b0;
    endtask

    function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] a);
        if (!re || a == 5'd0) return 32'd0;
        if (m_wd && m_addr == a) return m_data;
        return mregs[a];
    endfunction

    task automatic model_edge();
        if (!rst) return;
        if (m_wd && m_addr != 5'd0) mregs[m_addr] = m_data;
        if (flush) begin
            m_data = 32'd0;
            m_addr = 5'd0;
            m_wd   = 1'b0;
        end else if (!stall) begin
            m_data = i_w_reg_data;
            m_addr = i_w_reg_addr;
            m_wd   = i_wd;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("wb_data", wb_w_reg_data, m_data);
        chk("wb_addr", 32'(wb_w_reg_addr), 32'(m_addr));
        chk("wb_wd", 32'(wb_wd), 32'(m_wd));
    endtask

    task automatic drive(input logic wd, input logic [4:0] a, input logic [31:0] d);
        i_wd = wd;
        i_w_reg_addr = a;
        i_w_reg_data = d;
    endtask

    task automatic rd_both(input string tag, input logic [4:0] a, input logic [31:0] exp);
        re1 = 1'b1;
        re2 = 1'b1;
        raddr1 = a;
        raddr2 = a;
        #1;
        chk({tag, "_p1"}, rdata1, exp);
        chk({tag, "_p2"}, rdata2, exp);
    endtask

    task automatic rd_model(input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
        re1 = e1;
        re2 = e2;
        raddr1 = a1;
        raddr2 = a2;
        #1;
        chk("rnd_p1", rdata1, exp_rd(e1, a1));
        chk("rnd_p2", rdata2, exp_rd(e2, a2));
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        re1 = 1'b1;
        re2 = 1'b1;
        raddr1 = 5'd0;
        raddr2 = 5'd0;
        drive(1'b1, 5'd5, 32'hCAFE_F00D);
        model_reset();

        // Test 1: reset with nonzero inputs, clock running.
        #5 rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("t1_wb_data", wb_w_reg_data, 32'd0);
        chk("t1_wb_addr", 32'(wb_w_reg_addr), 32'd0);
        chk("t1_wb_wd", 32'(wb_wd), 32'd0);
        for (int a = 1; a < 32; a++) rd_both("t1_zero", 5'(a), 32'd0);
        i_wd = 1'b0;
        #5 rst = 1'b1;
        tick();
        rd_both("t1_nowd_nobyp", 5'd5, 32'd0);

        // Test 2: bypass then array.
        drive(1'b1, 5'd5, 32'hDEAD_BEEF);
        tick();
        rd_both("t2_bypass", 5'd5, 32'hDEAD_BEEF);
        drive(1'b0, 5'd6, 32'h0);
        tick();
        rd_both("t2_array", 5'd5, 32'hDEAD_BEEF);

        // Test 3: register 0 never written.
        drive(1'b1, 5'd0, 32'h1234_5678);
        tick();
        chk("t3_wb_wd", 32'(wb_wd), 32'd1);
        rd_both("t3_r0_now", 5'd0, 32'd0);
        drive(1'b0, 5'd0, 32'd0);
        tick();
        rd_both("t3_r0_after", 5'd0, 32'd0);

        // Test 4: stall holds the latch, bypass stays correct.
        drive(1'b1, 5'd7, 32'h11);
        tick();
        drive(1'b1, 5'd7, 32'h22);
        tick();
        rd_both("t4_r7_22", 5'd7, 32'h22);
        stall = 1'b1;
        drive(1'b1, 5'd8, 32'h99);
        for (int k = 0; k < 3; k++) begin
            tick();
            rd_both("t4_stall_r7", 5'd7, 32'h22);
            rd_both("t4_stall_r8", 5'd8, 32'd0);
        end
        stall = 1'b0;
        drive(1'b1, 5'd7, 32'h33);
        tick();
        rd_both("t4_r7_33_byp", 5'd7, 32'h33);
        drive(1'b0, 5'd0, 32'd0);
        tick();
        rd_both("t4_r7_33_arr", 5'd7, 32'h33);

        // Test 5: flush commits the replaced entry; flushed input is dropped.
        drive(1'b1, 5'd9, 32'hAA);
        tick();
        flush = 1'b1;
        stall = 1'b1;
        drive(1'b1, 5'd12, 32'h77);
        tick();
        chk("t5_wb_wd", 32'(wb_wd), 32'd0);
        rd_both("t5_r9", 5'd9, 32'hAA);
        rd_both("t5_r12", 5'd12, 32'd0);
        stall = 1'b0;
        drive(1'b1, 5'd10, 32'hBB);
        tick();
        rd_both("t5_r10_flushed", 5'd10, 32'd0);
        flush = 1'b0;
        drive(1'b0, 5'd0, 32'd0);
        tick();
        rd_both("t5_r10_after", 5'd10, 32'd0);

        // Test 6: asynchronous reset mid-cycle clears everything.
        drive(1'b1, 5'd3, 32'h55);
        tick();
        drive(1'b0, 5'd0, 32'd0);
        tick();
        rd_both("t6_r3_committed", 5'd3, 32'h55);
        #10 rst = 1'b0;
        model_reset();
        #1;
        rd_both("t6_r3_reset", 5'd3, 32'd0);
        chk("t6_wb_wd", 32'(wb_wd), 32'd0);
        #5 rst = 1'b1;
        drive(1'b1, 5'd4, 32'h66);
        tick();
        rd_both("t6_r4_first", 5'd4, 32'h66);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            i_wd  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0)
                i_w_reg_addr = 5'($urandom_range(0, 7));
            else
                i_w_reg_addr = 5'($urandom_range(0, 31));
            i_w_reg_data = $urandom;
            tick();
            begin
                logic [4:0] a1;
                logic [4:0] a2;
                a1 = ($urandom_range(0, 1) == 0) ? m_addr : 5'($urandom_range(0, 31));
                a2 = ($urandom_range(0, 2) == 0) ? a1 : 5'($urandom_range(0, 7));
                rd_model(($urandom_range(0, 3) != 0), a1, ($urandom_range(0, 3) != 0), a2);
            end
            if ($urandom_range(0, 149) == 0) begin
                #5 rst = 1'b0;
                model_reset();
                #1 rd_model(1'b1, m_addr, 1'b1, 5'd1);
                #5 rst = 1'b1;
            end
        end
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 5'd0, 32'd0);
        tick();
        for (int a = 0; a < 32; a++) rd_model(1'b1, 5'(a), 1'b1, 5'(31 - a));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
